// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running horizontal/vertical counters with registered
// sync, blanking and position decodes. All outputs describe the same (h,v) position.
module vga_sync_gen #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter logic SYNC_ACTIVE = 1'b0,
   parameter int   CW          = 10
) (
   input  logic          clk_25mhz,
   input  logic          rst_n,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          line_end,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] C_H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] C_V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] C_H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] C_V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] C_HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] C_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] C_VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] C_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CW-1:0] r_h_cnt;
   logic [CW-1:0] r_v_cnt;

   logic w_h_last;
   logic w_v_last;
   logic w_hs_on;
   logic w_vs_on;
   logic w_vis;
   logic w_origin;

   assign w_h_last = (r_h_cnt == C_H_LAST);
   assign w_v_last = (r_v_cnt == C_V_LAST);
   assign w_hs_on  = (r_h_cnt >= C_HS_BEG) && (r_h_cnt <= C_HS_END);
   assign w_vs_on  = (r_v_cnt >= C_VS_BEG) && (r_v_cnt <= C_VS_END);
   assign w_vis    = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
   assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

   // Outputs are decoded from the pre-edge counter values, so they trail the counters by one cycle.
   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         video_on    <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
         hsync       <= w_hs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync       <= w_vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on    <= w_vis;
         pixel_x     <= r_h_cnt;
         pixel_y     <= r_v_cnt;
         line_end    <= w_h_last;
         frame_start <= w_origin;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameter sets run side by side, each with a reset/stimulus
// process feeding a queue of expected outputs that one shared monitor pops and compares.
module tb_vga_sync_gen;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       von;
      logic [9:0] x;
      logic [9:0] y;
      logic       le;
      logic       fs;
   } out_t;

   typedef struct packed {
      out_t o;
      logic r;
   } ent_t;

   // cfg0: full default timing; cfg1: default lines, short frame; cfg2: tiny build, active-high sync
   localparam int HA_A[3]   = '{640, 640, 4};
   localparam int HF_A[3]   = '{16, 16, 1};
   localparam int HS_A[3]   = '{96, 96, 2};
   localparam int HB_A[3]   = '{48, 48, 1};
   localparam int VA_A[3]   = '{480, 8, 3};
   localparam int VF_A[3]   = '{10, 2, 1};
   localparam int VS_A[3]   = '{2, 2, 1};
   localparam int VB_A[3]   = '{33, 3, 1};
   localparam int SA_A[3]   = '{0, 0, 1};
   localparam int RUN1_A[3] = '{2500, 36010, 200};
   localparam int RX_A[3]   = '{300, 300, 3};
   localparam int RY_A[3]   = '{4, 5, 2};
   localparam int RUN2_A[3] = '{900, 900, 60};

   logic clk;
   int   checks;
   int   errors;
   int   cnt[3];
   int   last_fs[3];
   int   hrun[3];
   int   vrun[3];
   int   vcnt[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int h_total(input int c);
      return HA_A[c] + HF_A[c] + HS_A[c] + HB_A[c];
   endfunction

   function automatic int v_total(input int c);
      return VA_A[c] + VF_A[c] + VS_A[c] + VB_A[c];
   endfunction

   function automatic out_t decode(input int c, input int h, input int v);
      out_t e;
      logic sa;
      sa    = (SA_A[c] != 0);
      e.x   = 10'(h);
      e.y   = 10'(v);
      e.von = (h < HA_A[c]) && (v < VA_A[c]);
      e.hs  = (h >= HA_A[c] + HF_A[c] && h <= HA_A[c] + HF_A[c] + HS_A[c] - 1) ? sa : ~sa;
      e.vs  = (v >= VA_A[c] + VF_A[c] && v <= VA_A[c] + VF_A[c] + VS_A[c] - 1) ? sa : ~sa;
      e.le  = (h == h_total(c) - 1);
      e.fs  = (h == 0) && (v == 0);
      return e;
   endfunction

   function automatic out_t rst_out(input int c);
      out_t e;
      e    = '0;
      e.hs = (SA_A[c] == 0);
      e.vs = (SA_A[c] == 0);
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : cfg
      logic       rst_n;
      logic       hs;
      logic       vs;
      logic       von;
      logic       le;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
      out_t       got;
      ent_t       q[$];
      bit         fin;
      int         mh;
      int         mv;

      assign got = {hs, vs, von, x, y, le, fs};

      vga_sync_gen #(
         .H_ACTIVE    (HA_A[g]),
         .H_FP        (HF_A[g]),
         .H_SYNC      (HS_A[g]),
         .H_BP        (HB_A[g]),
         .V_ACTIVE    (VA_A[g]),
         .V_FP        (VF_A[g]),
         .V_SYNC      (VS_A[g]),
         .V_BP        (VB_A[g]),
         .SYNC_ACTIVE (SA_A[g] != 0),
         .CW          (10)
      ) u_dut (
         .clk_25mhz   (clk),
         .rst_n       (rst_n),
         .hsync       (hs),
         .vsync       (vs),
         .video_on    (von),
         .pixel_x     (x),
         .pixel_y     (y),
         .line_end    (le),
         .frame_start (fs)
      );

      task automatic step();
         @(posedge clk);
         q.push_back('{o: decode(g, mh, mv), r: 1'b0});
         mh = mh + 1;
         if (mh == h_total(g)) begin
            mh = 0;
            mv = (mv == v_total(g) - 1) ? 0 : mv + 1;
         end
      endtask

      task automatic hold_reset(input int n);
         repeat (n) begin
            @(posedge clk);
            q.push_back('{o: rst_out(g), r: 1'b1});
         end
      endtask

      initial begin
         fin   = 1'b0;
         rst_n = 1'b0;
         mh    = 0;
         mv    = 0;
         hold_reset(5);
         #2 rst_n = 1'b1;
         repeat (RUN1_A[g]) step();
         while (!(mh == RX_A[g] && mv == RY_A[g])) step();
         // Pull reset between edges, while the outputs sit on the target position.
         @(posedge clk);
         #2 rst_n = 1'b0;
         q.push_back('{o: rst_out(g), r: 1'b1});
         hold_reset(2);
         #2 rst_n = 1'b1;
         mh = 0;
         mv = 0;
         repeat (RUN2_A[g]) step();
         fin = 1'b1;
      end
   end

   task automatic check_one(input int c, input ent_t en, input out_t gv);
      logic sa;
      int   want;
      sa = (SA_A[c] != 0);
      checks++;
      if (gv !== en.o) begin
         errors++;
         $display("FAIL cfg%0d outputs: got x=%0d y=%0d hs=%b vs=%b von=%b le=%b fs=%b; want x=%0d y=%0d hs=%b vs=%b von=%b le=%b fs=%b",
                  c, gv.x, gv.y, gv.hs, gv.vs, gv.von, gv.le, gv.fs,
                  en.o.x, en.o.y, en.o.hs, en.o.vs, en.o.von, en.o.le, en.o.fs);
      end
      if (en.r) begin
         cnt[c]     = 0;
         last_fs[c] = -1;
         hrun[c]    = 0;
         vrun[c]    = 0;
         vcnt[c]    = 0;
      end else begin
         if (gv.fs) begin
            if (last_fs[c] >= 0) begin
               checks++;
               if (cnt[c] - last_fs[c] != h_total(c) * v_total(c)) begin
                  errors++;
                  $display("FAIL cfg%0d frame_period: got %0d want %0d", c, cnt[c] - last_fs[c],
                           h_total(c) * v_total(c));
               end
            end
            last_fs[c] = cnt[c];
         end
         if (gv.hs === sa) hrun[c]++;
         else if (hrun[c] > 0) begin
            checks++;
            if (hrun[c] != HS_A[c]) begin
               errors++;
               $display("FAIL cfg%0d hsync_width: got %0d want %0d", c, hrun[c], HS_A[c]);
            end
            hrun[c] = 0;
         end
         if (gv.vs === sa) vrun[c]++;
         else if (vrun[c] > 0) begin
            checks++;
            if (vrun[c] != VS_A[c] * h_total(c)) begin
               errors++;
               $display("FAIL cfg%0d vsync_width: got %0d want %0d", c, vrun[c], VS_A[c] * h_total(c));
            end
            vrun[c] = 0;
         end
         if (gv.von === 1'b1) vcnt[c]++;
         if (gv.le === 1'b1) begin
            want = (int'(gv.y) < VA_A[c]) ? HA_A[c] : 0;
            checks++;
            if (vcnt[c] != want) begin
               errors++;
               $display("FAIL cfg%0d video_on_per_line y=%0d: got %0d want %0d", c, gv.y, vcnt[c], want);
            end
            vcnt[c] = 0;
         end
         cnt[c]++;
      end
   endtask

   initial begin
      int cyc;
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int i = 0; i < 3; i++) begin
         cnt[i]     = 0;
         last_fs[i] = -1;
         hrun[i]    = 0;
         vrun[i]    = 0;
         vcnt[i]    = 0;
      end
      while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         if (cfg[0].q.size() > 0) check_one(0, cfg[0].q.pop_front(), cfg[0].got);
         if (cfg[1].q.size() > 0) check_one(1, cfg[1].q.pop_front(), cfg[1].got);
         if (cfg[2].q.size() > 0) check_one(2, cfg[2].q.pop_front(), cfg[2].got);
      end
      checks++;
      if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
         errors++;
         $display("FAIL timeout: got %0d cycles without completion, want completion", cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
